// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, baud derivation helper and the state
//               encoding used by both halves of the UART loopback.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    // Integer division: any fractional clock per bit is dropped.
    function automatic int calc_bit_cycles(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    localparam int BIT_CYCLES  = calc_bit_cycles(DEFAULT_CLK_FREQ, DEFAULT_BAUD_RATE);
    localparam int HALF_CYCLES = BIT_CYCLES / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_rx_loopback_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_rx_loopback_if
// Description : User-side signals of the UART loopback block.
//               master : drives manual_start / uart_data_in, observes results
//               slave  : the loopback block itself
//   manual_start   transmit request (rising edge starts one frame)
//   uart_data_in   byte to transmit
//   uart_data_out  last correctly received byte
//   uart_done      1-cycle pulse when uart_data_out updates
//   tx_done        1-cycle pulse at the end of the transmitted stop bit
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_rx_loopback_if;

    logic       manual_start;
    logic [7:0] uart_data_in;
    logic [7:0] uart_data_out;
    logic       uart_done;
    logic       tx_done;

    modport master (
        output manual_start,
        output uart_data_in,
        input  uart_data_out,
        input  uart_done,
        input  tx_done
    );

    modport slave (
        input  manual_start,
        input  uart_data_in,
        output uart_data_out,
        output uart_done,
        output tx_done
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 receiver with line synchroniser, start-bit glitch
//               rejection and framing-error discard.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   i_line  serial line, idle high
//   o_data  last correctly framed byte, held between frames
//   o_done  1-cycle pulse when o_data updates
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int BIT_CYCLES = uart_pkg::BIT_CYCLES
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_line,
    output logic [7:0]      o_data,
    output logic            o_done
);
    import uart_pkg::*;

    localparam int               HALF_CYCLES = BIT_CYCLES / 2;
    localparam int               CNT_W       = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic              w_fall;
    uart_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        r_data;
    logic              r_done;

    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    if (w_fall) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Half a bit in: still low means a real start bit, and
                    // every later sample lands on a bit centre.
                    if (r_cnt == c_half_last) begin
                        r_cnt   <= '0;
                        r_state <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        // A low stop bit is a framing error: drop the byte.
                        if (r_sync2) begin
                            r_data <= r_shift;
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data = r_data;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : Start-request synchroniser and rising-edge detector, plus
//               8N1 transmitter driving a registered serial line.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_start    asynchronous transmit request (edge triggered)
//   i_data     byte latched on the detected start edge
//   o_line     serial line, idle high
//   o_tx_done  1-cycle pulse on the last clock of the stop bit
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_core #(
    parameter int BIT_CYCLES = uart_pkg::BIT_CYCLES
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_start,
    input  wire logic [7:0] i_data,
    output logic            o_line,
    output logic            o_tx_done
);
    import uart_pkg::*;

    localparam int              CNT_W      = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(BIT_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;
    logic              w_start_pulse;
    uart_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_line;
    logic              r_tx_done;

    // Synchroniser clears to 0, so a level already high at reset release
    // still produces one edge.
    assign w_start_pulse = r_sync2 & ~r_sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_line    <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_sync1   <= i_start;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_line    <= 1'b1;
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    if (w_start_pulse) begin
                        r_shift <= i_data;
                        r_line  <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_line  <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        // The line always presents r_shift[0]; shifting right
                        // exposes the next bit one period later.
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_line    <= 1'b1;
                            r_state   <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_line    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt     <= '0;
                        r_tx_done <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_line  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_line    = r_line;
    assign o_tx_done = r_tx_done;

endmodule
`default_nettype wire

// File: rtl/uart_tx_rx_loopback.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_rx_loopback
// Description : UART link self-test. A rising edge on manual_start sends
//               uart_data_in as an 8N1 frame on an internal line that feeds
//               a receiver; the received byte appears on uart_data_out.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of uart_tx_rx_loopback_if (manual_start,
//          uart_data_in, uart_data_out, uart_done, tx_done)
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_rx_loopback #(
    parameter int CLK_FREQ  = uart_pkg::DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = uart_pkg::DEFAULT_BAUD_RATE
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    uart_tx_rx_loopback_if.slave    bus
);
    import uart_pkg::*;

    localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD_RATE);

    logic w_line;

    uart_tx_core #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (bus.manual_start),
        .i_data    (bus.uart_data_in),
        .o_line    (w_line),
        .o_tx_done (bus.tx_done)
    );

    uart_rx_core #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_line (w_line),
        .o_data (bus.uart_data_out),
        .o_done (bus.uart_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_rx_loopback.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_rx_loopback
// Description : Directed self-checking bench for uart_tx_rx_loopback
//               (50 MHz / 115200 -> 434 clocks per bit).
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_rx_loopback;

    localparam int          c_bit      = 434;
    localparam logic [9:0]  c_c9_bits  = 10'h392;  // 0,1,0,0,1,0,0,1,1,1 on the line, bit 0 first

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n_done;
    int   n_tx;
    int   n_low;

    uart_tx_rx_loopback_if bus ();

    uart_tx_rx_loopback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.uart_done === 1'b1) n_done <= n_done + 1;
        if (bus.tx_done === 1'b1)   n_tx   <= n_tx + 1;
        if (dut.w_line === 1'b0)    n_low  <= n_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge where manual_start was raised (or rst released
    // with it high). Checks latency, line bits, pulse timing and the byte.
    task automatic frame(input string tag, input bit scramble);
        int         k;
        int         idx;
        int         done_t;
        int         tx_t;
        int         d0;
        int         x0;
        logic [9:0] bits;
        d0     = n_done;
        x0     = n_tx;
        k      = 0;
        done_t = -1;
        tx_t   = -1;
        bits   = '0;
        while (dut.w_line !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 3);
        for (int t = 1; t <= 4500; t++) begin
            @(negedge clk);
            if (scramble && t == 1) bus.uart_data_in = 8'h00;
            idx = t / c_bit;
            if ((t % c_bit) == c_bit / 2 && idx < 10) bits[idx] = dut.w_line;
            if (bus.uart_done === 1'b1 && done_t < 0) done_t = t;
            if (bus.tx_done === 1'b1) begin
                tx_t = t;
                break;
            end
        end
        check({tag, "_bits"}, bits, c_c9_bits);
        check({tag, "_tx_done_t"}, tx_t, 10 * c_bit);
        check({tag, "_done_window"}, (done_t >= 4125 && done_t <= 4126), 1);
        check({tag, "_data_out"}, bus.uart_data_out, 8'hC9);
        @(negedge clk);
        check({tag, "_tx_done_1cyc"}, bus.tx_done, 1'b0);
        check({tag, "_n_done"}, n_done - d0, 1);
        check({tag, "_n_tx"}, n_tx - x0, 1);
    endtask

    initial begin
        int d0;
        int x0;
        int l0;
        int k;
        n_tests = 0;
        n_fail  = 0;
        n_done  = 0;
        n_tx    = 0;
        n_low   = 0;
        rst_n   = 1'b0;
        bus.manual_start = 1'b0;
        bus.uart_data_in = 8'h00;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_data_out", bus.uart_data_out, 8'h00);
        check("rst_uart_done", bus.uart_done, 1'b0);
        check("rst_tx_done", bus.tx_done, 1'b0);
        check("rst_line", dut.w_line, 1'b1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: basic frame of 0xC9
        bus.uart_data_in = 8'hC9;
        bus.manual_start = 1'b1;
        frame("t1", 1'b0);

        // 3: second frame right after, input changed after the latch
        bus.manual_start = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_hold", bus.uart_data_out, 8'hC9);
        bus.manual_start = 1'b1;
        frame("t3", 1'b1);
        bus.uart_data_in = 8'hC9;
        bus.manual_start = 1'b0;
        repeat (5) @(negedge clk);

        // 2: level held for one bit time sends exactly one frame
        d0 = n_done;
        x0 = n_tx;
        bus.manual_start = 1'b1;
        repeat (c_bit) @(negedge clk);
        bus.manual_start = 1'b0;
        repeat (19 * c_bit) @(negedge clk);
        check("t2_n_done", n_done - d0, 1);
        check("t2_n_tx", n_tx - x0, 1);
        check("t2_data_out", bus.uart_data_out, 8'hC9);

        // 4: inputs ignored while in reset
        rst_n = 1'b0;
        #1;
        check("t4_async_clear", bus.uart_data_out, 8'h00);
        d0 = n_done;
        x0 = n_tx;
        l0 = n_low;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.manual_start = 1'b1;
            repeat (5) @(negedge clk);
            bus.manual_start = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("t4_line", dut.w_line, 1'b1);
        check("t4_data_out", bus.uart_data_out, 8'h00);
        check("t4_no_done", n_done - d0, 0);
        check("t4_no_tx", n_tx - x0, 0);
        check("t4_no_low", n_low - l0, 0);

        // 5: released with manual_start low: nothing happens
        rst_n = 1'b1;
        repeat (11 * c_bit) @(negedge clk);
        check("t5_no_done", n_done - d0, 0);
        check("t5_no_tx", n_tx - x0, 0);
        check("t5_no_low", n_low - l0, 0);
        check("t5_line", dut.w_line, 1'b1);

        // 6: good frame, then reset after the start bit and four data bits
        bus.manual_start = 1'b1;
        frame("t6a", 1'b0);
        bus.manual_start = 1'b0;
        repeat (3) @(negedge clk);
        bus.manual_start = 1'b1;
        k = 0;
        while (dut.w_line !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_latency", k, 3);
        repeat (5 * c_bit) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_abort_line", dut.w_line, 1'b1);
        check("t6_abort_data", bus.uart_data_out, 8'h00);
        check("t6_abort_done", bus.uart_done, 1'b0);
        check("t6_abort_tx", bus.tx_done, 1'b0);
        bus.manual_start = 1'b0;
        d0 = n_done;
        x0 = n_tx;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        l0 = n_low;
        repeat (12 * c_bit) @(negedge clk);
        check("t6_no_done", n_done - d0, 0);
        check("t6_no_tx", n_tx - x0, 0);
        check("t6_no_low", n_low - l0, 0);
        check("t6_data_out", bus.uart_data_out, 8'h00);

        // 7: level high through reset release counts as one edge
        rst_n = 1'b0;
        bus.manual_start = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        frame("t7", 1'b0);
        bus.manual_start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
